mac_sample_feeder: RTL and testbench

Source side of the sample stream consumed by the sum-of-squares accumulator.
- Buffers 8-bit samples written by a host in a small FIFO.
- On command, emits a contiguous burst of N samples on a/valid_in, one per cycle, with no bubbles. The accumulator clears on any valid_in=0 cycle, so a bubble would corrupt the sum.
- Enforces an idle gap between bursts so each burst starts from a zeroed sum.

---
 rtl/mac_pkg.sv | 7 +
 rtl/sample_fifo.sv | 52 +++++
 rtl/mac_sample_feeder.sv | 108 ++++++++++
 tb/tb_mac_sample_feeder.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// mac_pkg: shared types and widths for the sum-of-squares sample path
package mac_pkg;
  localparam int DATA_W = 8;
  localparam int ACC_W  = 20;
  typedef logic [DATA_W-1:0] sample_t;
  typedef enum logic [1:0] {IDLE, WAIT, BURST, GAP} feeder_state_t;
endpackage

// File: rtl/sample_fifo.sv
// sample_fifo: registered-count synchronous FIFO, no fall-through
module sample_fifo
  import mac_pkg::*;
#(
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  sample_t       din,
  output sample_t       dout,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);
  sample_t       mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] count_q, count_d;
  logic          full_q, full_d, empty_q, empty_d, do_push, do_pop;
  always_comb begin
    do_push = push && !full_q;
    do_pop  = pop && !empty_q;
    wr_d    = wr_q + AW'(do_push);
    rd_d    = rd_q + AW'(do_pop);
    count_d = count_q + CW'(do_push) - CW'(do_pop);
    full_d  = count_d == CW'(DEPTH);
    empty_d = count_d == '0;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
      full_q  <= full_d;
      empty_q <= empty_d;
    end
  always_ff @(posedge clk)
    if (do_push) mem_q[wr_q] <= din;
  assign dout  = mem_q[rd_q];
  assign full  = full_q;
  assign empty = empty_q;
  assign count = count_q;
endmodule

// File: rtl/mac_sample_feeder.sv
// mac_sample_feeder: buffers host samples and emits bubble-free bursts to the accumulator
module mac_sample_feeder
  import mac_pkg::*;
#(
  parameter  int DEPTH   = 8,
  parameter  int LEN_W   = 4,
  parameter  int GAP_CYC = 2,
  localparam int CW      = $clog2(DEPTH + 1),
  localparam int GW      = $clog2(GAP_CYC + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  sample_t          wr_data,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  output sample_t          a,
  output logic             valid_in,
  output logic             last,
  output logic             done,
  output logic             busy,
  output logic             full,
  output logic [CW-1:0]    count,
  output logic             err
);
  feeder_state_t    state_q, state_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic [GW-1:0]    gap_q, gap_d;
  sample_t          a_q, a_d, fifo_dout;
  logic             valid_q, valid_d, last_q, last_d, done_q, done_d;
  logic             busy_q, busy_d, err_q, err_d, pop, len_ok, fifo_empty;
  sample_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (wr_en),
    .pop   (pop),
    .din   (wr_data),
    .dout  (fifo_dout),
    .full  (full),
    .empty (fifo_empty),
    .count (count)
  );
  assign len_ok = len != '0 && int'(len) <= DEPTH;
  // WAIT holds until the whole burst is buffered, so BURST never starves
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    gap_d   = gap_q;
    busy_d  = busy_q;
    pop     = state_q == BURST && !fifo_empty;
    a_d     = pop ? fifo_dout : '0;
    valid_d = pop;
    last_d  = pop && rem_q == LEN_W'(1);
    done_d  = state_q == GAP && gap_q == '0;
    err_d   = (wr_en && full) || (state_q == IDLE && start && !len_ok);
    case (state_q)
      IDLE:  if (start && len_ok) begin
        state_d = WAIT;
        rem_d   = len;
        busy_d  = 1'b1;
      end
      WAIT:  state_d = int'(count) >= int'(rem_q) ? BURST : WAIT;
      BURST: begin
        rem_d = rem_q - 1'b1;
        if (rem_q == LEN_W'(1)) begin
          state_d = GAP;
          gap_d   = '0;
        end
      end
      GAP:   begin
        gap_d = gap_q + 1'b1;
        if (gap_q == GW'(GAP_CYC - 1)) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q <= IDLE;
      rem_q   <= '0;
      gap_q   <= '0;
      a_q     <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      gap_q   <= gap_d;
      a_q     <= a_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  assign a        = a_q;
  assign valid_in = valid_q;
  assign last     = last_q;
  assign done     = done_q;
  assign busy     = busy_q;
  assign err      = err_q;
endmodule

// File: tb/tb_mac_sample_feeder.sv
// tb_mac_sample_feeder: scoreboard bench for the burst sample feeder
module tb_mac_sample_feeder;
  localparam int DEPTH = 8, LEN_W = 4, GAP_CYC = 2;
  logic             clk = 0, reset = 0, wr_en = 0, start = 0;
  logic [7:0]       wr_data = 0, a;
  logic [LEN_W-1:0] len = 0;
  logic             valid_in, last, done, busy, full, err;
  logic [3:0]       count;
  int               checks = 0, failures = 0;
  logic [7:0]       mq [$];
  int               blen [$];
  int               beat = 0, gap_left = 0;
  bit               pend_done = 0, prev_v = 0, prev_last = 0, exp_last = 0;

  mac_sample_feeder #(.DEPTH(DEPTH), .LEN_W(LEN_W), .GAP_CYC(GAP_CYC)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data), .start(start), .len(len),
    .a(a), .valid_in(valid_in), .last(last), .done(done), .busy(busy), .full(full),
    .count(count), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] x);
    bit ok;
    ok = mq.size() < DEPTH;
    wr_en = 1;
    wr_data = x;
    if (ok) mq.push_back(x);
    step();
    wr_en = 0;
    check("err_push", err, {31'b0, !ok});
  endtask

  task automatic start_cmd(input int l, input bit acc);
    start = 1;
    len = l[LEN_W-1:0];
    if (acc) blen.push_back(l);
    step();
    start = 0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 200) begin
      step();
      n++;
    end
    check("idle_timeout", busy, 0);
    repeat (2) step();
    check("beats_left", blen.size(), 0);
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      mq.delete();
      blen.delete();
      beat = 0; pend_done = 0; gap_left = 0; prev_v = 0; prev_last = 0;
    end else begin
      check("done", done, pend_done);
      pend_done = 0;
      if (gap_left > 0) begin
        check("gap_valid", valid_in, 0);
        gap_left--;
      end
      if (prev_v && !prev_last) check("contig", valid_in, 1);
      exp_last = 0;
      if (valid_in && (mq.size() == 0 || blen.size() == 0)) check("unexp_beat", valid_in, 0);
      else if (valid_in) begin
        exp_last = beat + 1 == blen[0];
        check("a", a, mq.pop_front());
        check("last", last, exp_last);
        beat++;
        if (exp_last) begin
          void'(blen.pop_front());
          beat = 0;
          pend_done = 1;
          gap_left = GAP_CYC;
        end
      end else check("a_idle", a, 0);
      prev_v = valid_in;
      prev_last = exp_last;
    end
  end

  initial begin
    repeat (3) step();
    check("rst_a", a, 0);
    check("rst_valid", valid_in, 0);
    check("rst_last", last, 0);
    check("rst_done", done, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    check("rst_count", count, 0);
    check("rst_full", full, 0);
    reset = 1;
    step();
    // basic burst with latency check
    push(1); push(2); push(3);
    check("count3", count, 3);
    start_cmd(3, 1);
    check("busy_on", busy, 1);
    step();
    check("lat_wait", valid_in, 0);
    step();
    check("lat_first", valid_in, 1);
    wait_idle();
    check("count_basic", count, 0);
    // burst waits for data
    push(50);
    start_cmd(4, 1);
    repeat (3) begin
      step();
      check("wait_novalid", valid_in, 0);
      check("wait_busy", busy, 1);
    end
    push(10); push(20); push(30);
    wait_idle();
    check("count_wait", count, 0);
    // overflow, full burst across pointer wrap, then short wrapped burst
    for (int i = 0; i < 9; i++) push(i[7:0]);
    check("full", full, 1);
    check("count_full", count, DEPTH);
    start_cmd(8, 1);
    wait_idle();
    check("count_drain", count, 0);
    check("full_clr", full, 0);
    push(100); push(101);
    start_cmd(2, 1);
    wait_idle();
    // illegal commands
    start_cmd(0, 0);
    check("err_len0", err, 1);
    check("busy_len0", busy, 0);
    start_cmd(9, 0);
    check("err_len9", err, 1);
    check("busy_len9", busy, 0);
    push(1); push(2); push(3);
    start_cmd(3, 1);
    step();
    start_cmd(2, 0);
    check("err_busy_start", err, 0);
    wait_idle();
    check("count_ign", count, 0);
    // concurrent push and pop
    push(11); push(12); push(13);
    start_cmd(3, 1);
    step();
    repeat (3) begin
      push(7);
      check("count_const", count, 3);
    end
    wait_idle();
    check("count_sevens", count, 3);
    start_cmd(3, 1);
    wait_idle();
    // reset mid-burst
    push(3); push(4); push(5);
    start_cmd(3, 1);
    repeat (3) step();
    check("pre_rst_valid", valid_in, 1);
    #1 reset = 0;
    #1;
    check("mid_rst_valid", valid_in, 0);
    check("mid_rst_a", a, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_count", count, 0);
    check("mid_rst_last", last, 0);
    step();
    reset = 1;
    repeat (4) begin
      step();
      check("post_rst_valid", valid_in, 0);
    end
    check("post_rst_busy", busy, 0);
    check("post_rst_count", count, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
